kernel_row_feeder: RTL

- Converts one raster-order pixel stream into BLOCK_HEIGHT vertically aligned row streams, one pixel per row per transfer, for the kernel window stage.
- Holds the previous BLOCK_HEIGHT-1 image lines internally.
- Emits one column of BLOCK_HEIGHT pixels (same image column, consecutive rows) per accepted input pixel, once enough lines are buffered.
- Sits between the pixel source (camera or DMA) and the kernel; its outputs connect bit-for-bit to the kernel's per-row pixel, valid and ready buses.

---
 rtl/hog_pkg.sv | 8 +
 rtl/line_column_store.sv | 27 ++
 rtl/kernel_row_feeder.sv | 75 +++++++
 3 files changed

// File: rtl/hog_pkg.sv
// hog_pkg: shared pixel/image constants and feeder state type.
package hog_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int IMG_WIDTH  = 640;
    localparam int IMG_HEIGHT = 480;
    localparam int ROW_SLICE  = DATA_WIDTH;
    typedef enum logic {FILL, STREAM} state_t;
endpackage

// File: rtl/line_column_store.sv
// line_column_store: DEPTH buffered lines, shifted up one line per write at a column.
module line_column_store #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2,
    parameter int IMG_WIDTH  = 640,
    parameter int COL_W      = $clog2(IMG_WIDTH)
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [COL_W-1:0]            col,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [DATA_WIDTH*DEPTH-1:0] column
);
    logic [DATA_WIDTH-1:0] mem [DEPTH][IMG_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < DEPTH-1; k++)
                mem[k][col] <= mem[k+1][col];
            mem[DEPTH-1][col] <= din;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_rd
        assign column[k*DATA_WIDTH +: DATA_WIDTH] = mem[k][col];
    end
endmodule

// File: rtl/kernel_row_feeder.sv
// kernel_row_feeder: turns a raster pixel stream into BLOCK_HEIGHT aligned row streams.
module kernel_row_feeder
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH   = hog_pkg::DATA_WIDTH,
    parameter int BLOCK_HEIGHT = 3,
    parameter int IMG_WIDTH    = hog_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT   = hog_pkg::IMG_HEIGHT,
    parameter int COL_W        = $clog2(IMG_WIDTH),
    parameter int ROW_W        = $clog2(IMG_HEIGHT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                in_pixel,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [DATA_WIDTH*BLOCK_HEIGHT-1:0]   out_pixels,
    output logic [BLOCK_HEIGHT-1:0]              out_valid,
    input  logic [BLOCK_HEIGHT-1:0]              out_ready,
    output logic                                 frame_done
);
    state_t                                state;
    logic [COL_W-1:0]                      col;
    logic [ROW_W-1:0]                      row;
    logic [DATA_WIDTH*(BLOCK_HEIGHT-1)-1:0] column;
    logic                                  acc, xfer, last_col, last_row;

    assign xfer     = out_valid[0] && (&out_ready);
    assign in_ready = (state == FILL) || !out_valid[0] || (&out_ready);
    assign acc      = in_valid && in_ready;
    assign last_col = col == COL_W'(IMG_WIDTH-1);
    assign last_row = row == ROW_W'(IMG_HEIGHT-1);

    line_column_store #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (BLOCK_HEIGHT-1),
        .IMG_WIDTH (IMG_WIDTH),
        .COL_W     (COL_W)
    ) u_store (
        .clk   (clk),
        .we    (acc),
        .col   (col),
        .din   (in_pixel),
        .column(column)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            col        <= '0;
            row        <= '0;
            out_valid  <= '0;
            out_pixels <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= acc && last_col && last_row;
            // a new column overwrites the register even while it is being transferred
            if (acc && state == STREAM) begin
                out_pixels <= {in_pixel, column};
                out_valid  <= '1;
            end else if (xfer) begin
                out_valid <= '0;
            end
            if (acc) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col)
                    row <= last_row ? '0 : row + 1'b1;
                if (state == FILL && last_col && row == ROW_W'(BLOCK_HEIGHT-2))
                    state <= STREAM;
                else if (state == STREAM && last_col && last_row)
                    state <= FILL;
            end
        end
    end
endmodule
